processor_run_ctrl: RTL and testbench

- Run controller that sequences the single-cycle processor through reset, execution and halt.
- Drives the processor's start_up and a clock-enable.
- Detects program completion: a halt word, a branch-to-self loop, or a cycle budget running out.
- Counts executed cycles and memory stores, and reports why the run ended. Sits between the test harness/top level and the processor instance.

---
 rtl/processor_run_ctrl_pkg.sv | 36 +++
 rtl/processor_run_ctrl_if.sv | 32 +++
 rtl/processor_run_ctrl_run_counter.sv | 42 ++++
 rtl/processor_run_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_processor_run_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/processor_run_ctrl_pkg.sv
// Shared definitions for the processor run controller: state encoding,
// halt-cause codes, the default halt instruction and cause arbitration.
package processor_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } run_state_e;

  localparam logic [1:0] HC_NONE     = 2'd0;
  localparam logic [1:0] HC_HALTWORD = 2'd1;
  localparam logic [1:0] HC_SELFLOOP = 2'd2;
  localparam logic [1:0] HC_TIMEOUT  = 2'd3;

  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  // When several halt conditions fire together, the lowest cause code wins.
  function automatic logic [1:0] select_cause(input logic hit_halt,
                                              input logic hit_loop,
                                              input logic hit_timeout);
    logic [1:0] cause;
    if (hit_halt) begin
      cause = HC_HALTWORD;
    end else if (hit_loop) begin
      cause = HC_SELFLOOP;
    end else if (hit_timeout) begin
      cause = HC_TIMEOUT;
    end else begin
      cause = HC_NONE;
    end
    return cause;
  endfunction

endpackage

// File: rtl/processor_run_ctrl_if.sv
// Bundle of the harness/processor-facing signals of the run controller.
// master: test harness + processor side. slave: the run controller.
interface processor_run_ctrl_if #(
  parameter int CNT_W = 32
);

  logic             go;
  logic             abort;
  logic [31:0]      instruction;
  logic [31:0]      pc_in;
  logic             mem_wr;
  logic             proc_start_up;
  logic             proc_clk_en;
  logic             running;
  logic             done;
  logic [1:0]       halt_cause;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] store_count;

  modport master (
    output go, abort, instruction, pc_in, mem_wr,
    input  proc_start_up, proc_clk_en, running, done, halt_cause,
           cycle_count, store_count
  );

  modport slave (
    input  go, abort, instruction, pc_in, mem_wr,
    output proc_start_up, proc_clk_en, running, done, halt_cause,
           cycle_count, store_count
  );

endinterface

// File: rtl/processor_run_ctrl_run_counter.sv
// Enabled up-counter with synchronous clear that sticks at all ones
// instead of wrapping.
module processor_run_ctrl_run_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_ONE = W'(1);
  localparam logic [W-1:0] CNT_SAT = {W{1'b1}};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise step while below saturation.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {W{1'b0}};
    end else if (en && (count_q != CNT_SAT)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/processor_run_ctrl.sv
// Run controller for the single-cycle processor: holds it in start-up,
// lets it execute, and stops it on a halt word, a branch-to-self or when
// the cycle budget is spent. Reports cycle/store counts and halt cause.
module processor_run_ctrl
  import processor_run_ctrl_pkg::*;
#(
  parameter int          RESET_CYCLES = 2,
  parameter int          MAX_CYCLES   = 1000,
  parameter logic [31:0] HALT_WORD    = DEFAULT_HALT_WORD,
  parameter int          CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  start_up_n,
  processor_run_ctrl_if.slave   bus
);

  // rst_cnt only needs to reach RESET_CYCLES-1.
  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RC_ZERO    = RC_W'(0);
  localparam logic [RC_W-1:0]  RC_ONE     = RC_W'(1);
  localparam logic [RC_W-1:0]  RC_LAST    = RC_W'(RESET_CYCLES - 1);
  // Count value that becomes MAX_CYCLES on the current RUN edge.
  localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(MAX_CYCLES - 1);

  run_state_e        state_q, state_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [31:0]       prev_pc_q, prev_pc_d;
  logic              prev_pc_valid_q, prev_pc_valid_d;
  logic              done_q, done_d;
  logic [1:0]        halt_cause_q, halt_cause_d;

  logic              cnt_clr_s;
  logic              cyc_en_s;
  logic              st_en_s;
  logic [CNT_W-1:0]  cycle_count_s;
  logic [CNT_W-1:0]  store_count_s;
  logic              hit_halt_s;
  logic              hit_loop_s;
  logic              hit_timeout_s;
  logic              proc_start_up_s;
  logic              proc_clk_en_s;
  logic              running_s;

  // Halt conditions from this cycle's processor outputs.
  always_comb begin
    hit_halt_s    = (bus.instruction == HALT_WORD);
    hit_loop_s    = prev_pc_valid_q && (bus.pc_in == prev_pc_q);
    hit_timeout_s = (cycle_count_s >= TIMEOUT_AT);
  end

  // Next-state, bookkeeping updates and counter controls.
  always_comb begin
    state_d         = state_q;
    rst_cnt_d       = rst_cnt_q;
    prev_pc_d       = prev_pc_q;
    prev_pc_valid_d = prev_pc_valid_q;
    halt_cause_d    = halt_cause_q;
    cnt_clr_s       = 1'b0;
    cyc_en_s        = 1'b0;
    st_en_s         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.go) begin
          state_d         = ST_RESET;
          rst_cnt_d       = RC_ZERO;
          cnt_clr_s       = 1'b1;
          halt_cause_d    = HC_NONE;
          prev_pc_valid_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RESET: begin
        if (bus.abort) begin
          state_d   = ST_IDLE;
          rst_cnt_d = RC_ZERO;
        end else if (rst_cnt_q == RC_LAST) begin
          state_d   = ST_RUN;
          rst_cnt_d = RC_ZERO;
        end else begin
          state_d   = ST_RESET;
          rst_cnt_d = rst_cnt_q + RC_ONE;
        end
      end

      ST_RUN: begin
        // Every RUN cycle is counted, including the one that ends the run.
        cyc_en_s        = 1'b1;
        st_en_s         = bus.mem_wr;
        prev_pc_d       = bus.pc_in;
        prev_pc_valid_d = 1'b1;
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (hit_halt_s || hit_loop_s || hit_timeout_s) begin
          state_d      = ST_DONE;
          halt_cause_d = select_cause(hit_halt_s, hit_loop_s, hit_timeout_s);
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.go) begin
          state_d         = ST_RESET;
          rst_cnt_d       = RC_ZERO;
          cnt_clr_s       = 1'b1;
          halt_cause_d    = HC_NONE;
          prev_pc_valid_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    done_d = (state_d == ST_DONE);
  end

  // Controller state and bookkeeping registers.
  always_ff @(posedge clk or negedge start_up_n) begin
    if (!start_up_n) begin
      state_q         <= ST_IDLE;
      rst_cnt_q       <= RC_ZERO;
      prev_pc_q       <= 32'h0000_0000;
      prev_pc_valid_q <= 1'b0;
      done_q          <= 1'b0;
      halt_cause_q    <= HC_NONE;
    end else begin
      state_q         <= state_d;
      rst_cnt_q       <= rst_cnt_d;
      prev_pc_q       <= prev_pc_d;
      prev_pc_valid_q <= prev_pc_valid_d;
      done_q          <= done_d;
      halt_cause_q    <= halt_cause_d;
    end
  end

  // Processor controls decode straight from state so an asynchronous
  // reset takes effect without waiting for a clock edge.
  always_comb begin
    proc_start_up_s = 1'b1;
    proc_clk_en_s   = 1'b0;
    running_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        proc_start_up_s = 1'b1;
        proc_clk_en_s   = 1'b0;
      end
      ST_RESET: begin
        proc_start_up_s = 1'b1;
        proc_clk_en_s   = 1'b1;
      end
      ST_RUN: begin
        proc_start_up_s = 1'b0;
        proc_clk_en_s   = 1'b1;
        running_s       = 1'b1;
      end
      ST_DONE: begin
        proc_start_up_s = 1'b0;
        proc_clk_en_s   = 1'b0;
      end
      default: begin
        proc_start_up_s = 1'b1;
        proc_clk_en_s   = 1'b0;
      end
    endcase
  end

  processor_run_ctrl_run_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (start_up_n),
    .clr   (cnt_clr_s),
    .en    (cyc_en_s),
    .count (cycle_count_s)
  );

  processor_run_ctrl_run_counter #(.W(CNT_W)) u_store_cnt (
    .clk   (clk),
    .rst_n (start_up_n),
    .clr   (cnt_clr_s),
    .en    (st_en_s),
    .count (store_count_s)
  );

  assign bus.proc_start_up = proc_start_up_s;
  assign bus.proc_clk_en   = proc_clk_en_s;
  assign bus.running       = running_s;
  assign bus.done          = done_q;
  assign bus.halt_cause    = halt_cause_q;
  assign bus.cycle_count   = cycle_count_s;
  assign bus.store_count   = store_count_s;

endmodule

// File: tb/tb_processor_run_ctrl.sv
// Directed bench for processor_run_ctrl (RESET_CYCLES=2, MAX_CYCLES=20).
module tb_processor_run_ctrl;

  localparam logic [31:0] HW = 32'hFFFF_FFFF;

  logic clk;
  logic start_up_n;
  int   total_cnt;
  int   pass_cnt;
  int   fail_cnt;

  processor_run_ctrl_if #(.CNT_W(32)) bus ();

  processor_run_ctrl #(
    .RESET_CYCLES (2),
    .MAX_CYCLES   (20),
    .HALT_WORD    (HW),
    .CNT_W        (32)
  ) dut (
    .clk        (clk),
    .start_up_n (start_up_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // go pulse then two RESET cycles; returns with the DUT in RUN.
  task automatic start_run();
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    fail_cnt  = 0;
    start_up_n      = 1'b0;
    bus.go          = 1'b0;
    bus.abort       = 1'b0;
    bus.instruction = 32'h0000_0000;
    bus.pc_in       = 32'h0000_0000;
    bus.mem_wr      = 1'b0;

    // Reset state
    #1;
    check("rst_start_up", 64'(bus.proc_start_up), 64'd1);
    check("rst_clk_en",   64'(bus.proc_clk_en),   64'd0);
    check("rst_running",  64'(bus.running),       64'd0);
    check("rst_done",     64'(bus.done),          64'd0);
    check("rst_cause",    64'(bus.halt_cause),    64'd0);
    check("rst_cycles",   64'(bus.cycle_count),   64'd0);
    check("rst_stores",   64'(bus.store_count),   64'd0);
    #11;
    start_up_n = 1'b1;

    // 1: start-up window, then halt word on RUN cycle 10
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    check("t1_rst1_start_up", 64'(bus.proc_start_up), 64'd1);
    check("t1_rst1_clk_en",   64'(bus.proc_clk_en),   64'd1);
    tick();
    check("t1_rst2_start_up", 64'(bus.proc_start_up), 64'd1);
    check("t1_rst2_clk_en",   64'(bus.proc_clk_en),   64'd1);
    tick();
    check("t1_run_start_up",  64'(bus.proc_start_up), 64'd0);
    check("t1_run_running",   64'(bus.running),       64'd1);
    for (int k = 1; k <= 10; k++) begin
      bus.pc_in       = 32'(4 * k);
      bus.instruction = (k == 10) ? HW : 32'h0000_0000;
      tick();
    end
    bus.instruction = 32'h0000_0000;
    check("t1_done",    64'(bus.done),        64'd1);
    check("t1_cause",   64'(bus.halt_cause),  64'd1);
    check("t1_cycles",  64'(bus.cycle_count), 64'd10);
    check("t1_clk_en",  64'(bus.proc_clk_en), 64'd0);
    check("t1_running", 64'(bus.running),     64'd0);

    // 2: pc 0x20 on RUN cycles 7 and 8 -> self-loop
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    check("t2_restart_cycles", 64'(bus.cycle_count), 64'd0);
    check("t2_restart_done",   64'(bus.done),        64'd0);
    tick();
    tick();
    for (int k = 1; k <= 8; k++) begin
      bus.pc_in = (k >= 7) ? 32'h0000_0020 : 32'(4 * k);
      tick();
    end
    check("t2_done",   64'(bus.done),        64'd1);
    check("t2_cause",  64'(bus.halt_cause),  64'd2);
    check("t2_cycles", 64'(bus.cycle_count), 64'd8);

    // 3: timeout after 20 cycles with 5 stores (last one on the halting cycle)
    start_run();
    for (int k = 1; k <= 20; k++) begin
      bus.pc_in  = 32'(4 * k);
      bus.mem_wr = (k == 2 || k == 5 || k == 9 || k == 14 || k == 20);
      tick();
      if (k == 19) begin
        check("t3_pre_running", 64'(bus.running),     64'd1);
        check("t3_pre_cycles",  64'(bus.cycle_count), 64'd19);
      end
    end
    bus.mem_wr = 1'b0;
    check("t3_cause",  64'(bus.halt_cause),  64'd3);
    check("t3_cycles", 64'(bus.cycle_count), 64'd20);
    check("t3_stores", 64'(bus.store_count), 64'd5);
    bus.mem_wr = 1'b1;
    tick();
    bus.mem_wr = 1'b0;
    check("t3_frozen_cycles", 64'(bus.cycle_count), 64'd20);
    check("t3_frozen_stores", 64'(bus.store_count), 64'd5);
    check("t3_frozen_done",   64'(bus.done),        64'd1);

    // 4: halt word and self-loop together -> halt word wins
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    check("t4_clear_cycles", 64'(bus.cycle_count), 64'd0);
    check("t4_clear_stores", 64'(bus.store_count), 64'd0);
    check("t4_clear_cause",  64'(bus.halt_cause),  64'd0);
    tick();
    tick();
    bus.pc_in = 32'h0000_0100;
    tick();
    bus.instruction = HW;
    tick();
    bus.instruction = 32'h0000_0000;
    check("t4_cause",  64'(bus.halt_cause),  64'd1);
    check("t4_cycles", 64'(bus.cycle_count), 64'd2);

    // 5: abort on RUN cycle 4
    start_run();
    for (int k = 1; k <= 4; k++) begin
      bus.pc_in = 32'(4 * k);
      bus.abort = (k == 4);
      tick();
    end
    bus.abort = 1'b0;
    check("t5_running",   64'(bus.running),       64'd0);
    check("t5_done",      64'(bus.done),          64'd0);
    check("t5_cause",     64'(bus.halt_cause),    64'd0);
    check("t5_cycles",    64'(bus.cycle_count),   64'd4);
    check("t5_start_up",  64'(bus.proc_start_up), 64'd1);
    check("t5_clk_en",    64'(bus.proc_clk_en),   64'd0);

    // 6: go ignored in RUN, then asynchronous reset mid-RUN
    start_run();
    for (int k = 1; k <= 3; k++) begin
      bus.pc_in = 32'(4 * k);
      bus.go    = (k == 2);
      tick();
      if (k == 2) begin
        check("t6_go_ignored_running",  64'(bus.running),       64'd1);
        check("t6_go_ignored_start_up", 64'(bus.proc_start_up), 64'd0);
      end
    end
    bus.go = 1'b0;
    check("t6_pre_cycles", 64'(bus.cycle_count), 64'd3);
    #2;
    start_up_n = 1'b0;
    #1;
    check("t6_async_start_up", 64'(bus.proc_start_up), 64'd1);
    check("t6_async_clk_en",   64'(bus.proc_clk_en),   64'd0);
    check("t6_async_running",  64'(bus.running),       64'd0);
    check("t6_async_cycles",   64'(bus.cycle_count),   64'd0);
    #3;
    start_up_n = 1'b1;

    // 7: abort beats go in DONE
    start_run();
    bus.pc_in       = 32'h0000_0040;
    bus.instruction = HW;
    tick();
    bus.instruction = 32'h0000_0000;
    check("t7_done",   64'(bus.done),        64'd1);
    check("t7_cycles", 64'(bus.cycle_count), 64'd1);
    bus.go    = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.go    = 1'b0;
    bus.abort = 1'b0;
    check("t7_done_cleared", 64'(bus.done),          64'd0);
    check("t7_start_up",     64'(bus.proc_start_up), 64'd1);
    check("t7_clk_en_idle",  64'(bus.proc_clk_en),   64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
